// File: rtl/key_reset_pkg.sv
// Shared constants for the pushbutton debounce / reset sequencer:
// reset-FSM state encodings, default parameter values and a counter-width helper.
package key_reset_pkg;

    localparam int N_KEYS_DEF          = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int RST_HOLD_CYCLES_DEF = 65536;
    localparam int LONG_PRESS_DEF      = 100000000;

    typedef logic [1:0] rst_state_t;

    localparam rst_state_t ST_ASSERT = 2'd0;
    localparam rst_state_t ST_HOLD   = 2'd1;
    localparam rst_state_t ST_RUN    = 2'd2;

    // A terminal count of n-1 fits in $clog2(n) bits; keep at least one bit for n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability-window debounce and
// one-cycle press/release pulses aligned with the debounced level edge.
module key_debounce
    import key_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int            CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample;

    always_comb begin
        sync_d   = {sync_q[0], key_n};
        sample   = ~sync_q[1];
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        // Any sample that agrees with the stable state restarts the window.
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            stable_d = sample;
            cnt_d    = '0;
            press_d  = sample;
            rel_d    = ~sample;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    assign key_level   = stable_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

endmodule

// File: rtl/key_reset_seq.sv
// Debounced pushbuttons plus a KEY[0]-driven system reset sequencer (ASSERT/HOLD/RUN).
// Defining KEY_RESET_LONGPRESS_EN adds the key_long port and per-key long-press detection.
module key_reset_seq
    import key_reset_pkg::*;
#(
    parameter int N_KEYS            = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int RST_HOLD_CYCLES   = RST_HOLD_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
`ifdef KEY_RESET_LONGPRESS_EN
    output logic [N_KEYS-1:0] key_long,
`endif
    output logic              sys_rst_n
);

    localparam int            HW      = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_TC = HW'(RST_HOLD_CYCLES - 1);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .key_n      (key_n[k]),
            .key_level  (key_level[k]),
            .key_press  (key_press[k]),
            .key_release(key_release[k])
        );
    end

    rst_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          sys_rst_n_q, sys_rst_n_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_ASSERT: begin
                hold_d = '0;
                if (!key_level[0]) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // A re-press during the hold forfeits all accumulated hold time.
                if (key_level[0]) begin
                    state_d = ST_ASSERT;
                    hold_d  = '0;
                end else if (hold_q == HOLD_TC) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (key_press[0]) state_d = ST_ASSERT;
            end
            default: begin
                state_d = ST_ASSERT;
                hold_d  = '0;
            end
        endcase
        sys_rst_n_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ASSERT;
            hold_q      <= '0;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            sys_rst_n_q <= sys_rst_n_d;
        end
    end

    assign sys_rst_n = sys_rst_n_q;

`ifdef KEY_RESET_LONGPRESS_EN
    localparam int            LW    = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LP_TC = LW'(LONG_PRESS_CYCLES - 1);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_long
        logic [LW-1:0] lp_cnt_q, lp_cnt_d;
        logic          fired_q, fired_d;
        logic          long_q, long_d;

        always_comb begin
            lp_cnt_d = lp_cnt_q;
            fired_d  = fired_q;
            long_d   = 1'b0;
            if (!key_level[k]) begin
                lp_cnt_d = '0;
                fired_d  = 1'b0;
            end else if (!fired_q) begin
                if (lp_cnt_q == LP_TC) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end else begin
                    lp_cnt_d = lp_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                lp_cnt_q <= '0;
                fired_q  <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                lp_cnt_q <= lp_cnt_d;
                fired_q  <= fired_d;
                long_q   <= long_d;
            end
        end

        assign key_long[k] = long_q;
    end
`endif

endmodule

// File: tb/tb_key_reset_seq.sv
// Directed bench for key_reset_seq with short debounce/hold/long-press parameters.
module tb_key_reset_seq;

    localparam int D = 8;
    localparam int H = 16;
    localparam int L = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_n;
    logic [1:0] key_level, key_press, key_release;
    logic       sys_rst_n;
`ifdef KEY_RESET_LONGPRESS_EN
    logic [1:0] key_long;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    key_reset_seq #(
        .N_KEYS           (2),
        .DEBOUNCE_CYCLES  (D),
        .RST_HOLD_CYCLES  (H),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
`ifdef KEY_RESET_LONGPRESS_EN
        .key_long   (key_long),
`endif
        .sys_rst_n  (sys_rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int seen_level, seen_press, n_long, long_at;

        // Reset with keys idle
        rst   = 1'b1;
        key_n = 2'b11;
        tick(5);
        check("rst_level",   32'(key_level),   32'd0);
        check("rst_press",   32'(key_press),   32'd0);
        check("rst_release", 32'(key_release), 32'd0);
        check("rst_sysrst",  32'(sys_rst_n),   32'd0);

        // First edge after reset enters HOLD; RUN 16 edges later
        rst = 1'b0;
        tick(1);
        check("hold_enter_sysrst", 32'(sys_rst_n), 32'd0);
        tick(15);
        check("hold_15_sysrst", 32'(sys_rst_n), 32'd0);
        tick(1);
        check("hold_16_sysrst", 32'(sys_rst_n), 32'd1);

        // Short glitch on KEY[1] must be swallowed
        seen_level = 0;
        seen_press = 0;
        key_n[1] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) key_n[1] = 1'b1;
            tick(1);
            if (key_level[1]) seen_level++;
            if (key_press[1]) seen_press++;
        end
        check("glitch_level", 32'(seen_level), 32'd0);
        check("glitch_press", 32'(seen_press), 32'd0);

        // Clean press / release on KEY[1]: latency 2 + D
        key_n[1] = 1'b0;
        tick(9);
        check("k1_lvl_9", 32'(key_level[1]), 32'd0);
        tick(1);
        check("k1_lvl_10",   32'(key_level[1]), 32'd1);
        check("k1_press_10", 32'(key_press[1]), 32'd1);
        tick(1);
        check("k1_press_11", 32'(key_press[1]), 32'd0);
        check("k1_sysrst",   32'(sys_rst_n),    32'd1);
        key_n[1] = 1'b1;
        tick(10);
        check("k1_rel_lvl",  32'(key_level[1]),   32'd0);
        check("k1_rel_10",   32'(key_release[1]), 32'd1);
        tick(1);
        check("k1_rel_11",   32'(key_release[1]), 32'd0);

        // Both keys together in RUN: simultaneous pulses, KEY[0] starts reset
        key_n = 2'b00;
        tick(9);
        check("both_press_9", 32'(key_press), 32'd0);
        tick(1);
        check("both_press_10", 32'(key_press), 32'd3);
        check("run_sysrst_10", 32'(sys_rst_n), 32'd1);
        tick(1);
        check("assert_sysrst_11", 32'(sys_rst_n), 32'd0);
        check("both_press_11",    32'(key_press), 32'd0);
        tick(9);
        key_n = 2'b11;
        tick(10);
        check("both_rel_10", 32'(key_release), 32'd3);
        tick(16);
        check("rel_hold_15_sysrst", 32'(sys_rst_n), 32'd0);
        tick(1);
        check("rel_hold_16_sysrst", 32'(sys_rst_n), 32'd1);

        // Re-press during HOLD: back to ASSERT, full hold after next release
        key_n[0] = 1'b0;
        tick(10);
        check("k0_press", 32'(key_press[0]), 32'd1);
        tick(10);
        key_n[0] = 1'b1;
        tick(10);
        check("k0_rel_lvl", 32'(key_level[0]), 32'd0);
        tick(1);
        key_n[0] = 1'b0;
        tick(10);
        check("rep_lvl_hold10", 32'(key_level[0]), 32'd1);
        tick(1);
        check("rep_sysrst", 32'(sys_rst_n), 32'd0);
        key_n[0] = 1'b1;
        tick(26);
        check("rep_hold_15_sysrst", 32'(sys_rst_n), 32'd0);
        tick(1);
        check("rep_hold_16_sysrst", 32'(sys_rst_n), 32'd1);

        // Reset mid-press: key re-debounced from scratch
        key_n[1] = 1'b0;
        tick(12);
        check("mid_lvl_before", 32'(key_level[1]), 32'd1);
        rst = 1'b1;
        tick(2);
        check("mid_lvl_rst",    32'(key_level[1]), 32'd0);
        check("mid_sysrst_rst", 32'(sys_rst_n),    32'd0);
        rst = 1'b0;
        tick(9);
        check("mid_lvl_9", 32'(key_level[1]), 32'd0);
        tick(1);
        check("mid_lvl_10",   32'(key_level[1]), 32'd1);
        check("mid_press_10", 32'(key_press[1]), 32'd1);

`ifdef KEY_RESET_LONGPRESS_EN
        // Held 60 cycles past debounce: one key_long pulse at held-count 40
        n_long  = 0;
        long_at = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (key_long[1]) begin
                n_long++;
                long_at = i;
            end
        end
        check("long_count", 32'(n_long),  32'd1);
        check("long_at",    32'(long_at), 32'(L));
`else
        n_long  = 0;
        long_at = 0;
        tick(60);
        check("held_lvl_60", 32'(key_level[1]), 32'd1);
`endif

        key_n = 2'b11;
        tick(12);
        check("final_lvl", 32'(key_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
